// File: rtl/data_mux_pkg.sv
// -----------------------------------------------------------------------------
// data_mux_pkg
// Shared definitions for the data_multiplex / data_demultiplex_rx pair:
// mode encodings, channel index constants, receive FSM states and the
// slot-schedule helper functions (start channel and next channel per mode).
// Keeping the schedule here guarantees both ends walk the channels in the
// same order.
// -----------------------------------------------------------------------------
package data_mux_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_REV  = 2'b10;
  localparam logic [1:0] MODE_FIX  = 2'b11;

  localparam int         NUM_CH  = 3;
  localparam logic [1:0] CH_NONE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_e;

  // First channel of a schedule: reverse starts at ch3 (index 2), the
  // others at ch1 (index 0).
  function automatic logic [1:0] start_ch(input logic [1:0] mode);
    logic [1:0] ch;
    case (mode)
      MODE_FWD: ch = 2'd0;
      MODE_REV: ch = 2'd2;
      MODE_FIX: ch = 2'd0;
      default:  ch = CH_NONE;
    endcase
    return ch;
  endfunction

  // Channel that follows `ch` in the given schedule.
  function automatic logic [1:0] next_ch(input logic [1:0] mode,
                                         input logic [1:0] ch);
    logic [1:0] nxt;
    case (mode)
      MODE_FWD: nxt = (ch == 2'd2) ? 2'd0 : ch + 2'd1;
      MODE_REV: nxt = (ch == 2'd0) ? 2'd2 : ch - 2'd1;
      MODE_FIX: nxt = 2'd0;
      default:  nxt = CH_NONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/slot_counter.sv
// -----------------------------------------------------------------------------
// slot_counter
// Slot-length latch and cycle counter for the demux schedule.
//   clk      : system clock
//   rst      : synchronous active-high reset (count=0, latched length=1)
//   load     : restart; count->0 and length re-latched from len_in
//   advance  : one receive cycle elapsed; count up, or wrap at terminal count
//   len_in   : requested slot length (0 is treated as 1)
//   tc       : current cycle is the last one of the slot
// The length is only sampled on load or on a wrap, so a change on len_in
// mid-slot waits for the next slot boundary.
// -----------------------------------------------------------------------------
module slot_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [CNT_W-1:0] len_in,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] eff_len;

  assign eff_len = (len_in == '0) ? CNT_W'(1) : len_in;

  // len_q is never 0, so len_q-1 cannot underflow.
  assign tc = (count_q == (len_q - CNT_W'(1)));

  always_comb begin
    count_d = count_q;
    len_d   = len_q;
    if (load) begin
      count_d = '0;
      len_d   = eff_len;
    end else if (advance) begin
      if (tc) begin
        count_d = '0;
        len_d   = eff_len;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      len_q   <= CNT_W'(1);
    end else begin
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: rtl/data_demultiplex_rx.sv
// -----------------------------------------------------------------------------
// data_demultiplex_rx
// Receive side of data_multiplex: steers each byte of the time-multiplexed
// stream into one of three channel registers using the same mode /
// switch_clk_cycles slot schedule as the mux.
//   clk, rst           : clock, synchronous active-high reset
//   in_data            : multiplexed stream
//   mode               : 00 idle, 01 fwd round-robin, 10 rev round-robin,
//                        11 fixed ch1
//   switch_clk_cycles  : slot length in cycles (0 behaves as 1)
//   sync               : realign schedule to slot start (ignored in IDLE)
//   ch1/ch2/ch3_data   : last byte captured in each channel's slot
//   slot_done          : one-hot, one cycle, channel whose slot just ended
//   cur_ch             : channel being received (3 = none)
//   err_cnt            : only with DEMUX_STABILITY_CHECK_EN; counts bytes
//                        that differ from the first byte of their slot,
//                        saturating at 255
// Optional build macro: DEMUX_STABILITY_CHECK_EN
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | mode==00; nothing captured, cur_ch=3, channel data held
// ST_RUN  | schedule active; in_data captured into cur_ch every cycle
// -----------------------------------------------------------------------------
module data_demultiplex_rx
  import data_mux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  switch_clk_cycles,
  input  logic              sync,
  output logic [DATA_W-1:0] ch1_data,
  output logic [DATA_W-1:0] ch2_data,
  output logic [DATA_W-1:0] ch3_data,
  output logic [2:0]        slot_done,
`ifdef DEMUX_STABILITY_CHECK_EN
  output logic [7:0]        err_cnt,
`endif
  output logic [1:0]        cur_ch
);

  rx_state_e         state_q, state_d;
  logic [1:0]        cur_ch_q, cur_ch_d;
  logic [1:0]        run_mode_q, run_mode_d;
  logic [DATA_W-1:0] ch1_q, ch1_d;
  logic [DATA_W-1:0] ch2_q, ch2_d;
  logic [DATA_W-1:0] ch3_q, ch3_d;
  logic [2:0]        slot_done_q, slot_done_d;

  logic cnt_load;
  logic cnt_advance;
  logic cnt_tc;

`ifdef DEMUX_STABILITY_CHECK_EN
  logic [DATA_W-1:0] ref_q, ref_d;
  logic              ref_vld_q, ref_vld_d;
  logic [7:0]        err_q, err_d;
`endif

  slot_counter #(
    .CNT_W (CNT_W)
  ) u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .advance (cnt_advance),
    .len_in  (switch_clk_cycles),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    run_mode_d  = run_mode_q;
    ch1_d       = ch1_q;
    ch2_d       = ch2_q;
    ch3_d       = ch3_q;
    slot_done_d = 3'b000;
    cnt_load    = 1'b0;
    cnt_advance = 1'b0;
`ifdef DEMUX_STABILITY_CHECK_EN
    ref_d       = ref_q;
    ref_vld_d   = ref_vld_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (mode != MODE_IDLE) begin
          state_d    = ST_RUN;
          cur_ch_d   = start_ch(mode);
          run_mode_d = mode;
          cnt_load   = 1'b1;
        end
      end

      ST_RUN: begin
        if (mode == MODE_IDLE) begin
          state_d  = ST_IDLE;
          cur_ch_d = CH_NONE;
`ifdef DEMUX_STABILITY_CHECK_EN
          ref_vld_d = 1'b0;
`endif
        end else if ((mode != run_mode_q) || sync) begin
          // Restart: the current slot is abandoned, this edge captures
          // nothing and no slot_done is raised even on a boundary.
          cur_ch_d   = start_ch(mode);
          run_mode_d = mode;
          cnt_load   = 1'b1;
`ifdef DEMUX_STABILITY_CHECK_EN
          ref_vld_d  = 1'b0;
`endif
        end else begin
          cnt_advance = 1'b1;
          case (cur_ch_q)
            2'd0:    ch1_d = in_data;
            2'd1:    ch2_d = in_data;
            2'd2:    ch3_d = in_data;
            default: ;
          endcase
`ifdef DEMUX_STABILITY_CHECK_EN
          if (!ref_vld_q) begin
            ref_d     = in_data;
            ref_vld_d = 1'b1;
          end else if ((in_data != ref_q) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
`endif
          if (cnt_tc) begin
            // Registered alongside the channel's final data update.
            slot_done_d = 3'b001 << cur_ch_q;
            cur_ch_d    = next_ch(run_mode_q, cur_ch_q);
`ifdef DEMUX_STABILITY_CHECK_EN
            ref_vld_d   = 1'b0;
`endif
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cur_ch_d = CH_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_ch_q    <= CH_NONE;
      run_mode_q  <= MODE_IDLE;
      ch1_q       <= '0;
      ch2_q       <= '0;
      ch3_q       <= '0;
      slot_done_q <= 3'b000;
`ifdef DEMUX_STABILITY_CHECK_EN
      ref_q       <= '0;
      ref_vld_q   <= 1'b0;
      err_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      run_mode_q  <= run_mode_d;
      ch1_q       <= ch1_d;
      ch2_q       <= ch2_d;
      ch3_q       <= ch3_d;
      slot_done_q <= slot_done_d;
`ifdef DEMUX_STABILITY_CHECK_EN
      ref_q       <= ref_d;
      ref_vld_q   <= ref_vld_d;
      err_q       <= err_d;
`endif
    end
  end

  assign ch1_data  = ch1_q;
  assign ch2_data  = ch2_q;
  assign ch3_data  = ch3_q;
  assign slot_done = slot_done_q;
  assign cur_ch    = cur_ch_q;
`ifdef DEMUX_STABILITY_CHECK_EN
  assign err_cnt   = err_q;
`endif

endmodule
